// File: rtl/bitwise_pkg.sv
// Shared encodings for the bitwise NAND-unit sequencer: operation codes,
// FSM states and the default datapath width.
package bitwise_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CNT_W     = 4;

  typedef enum logic [1:0] {
    OP_NAND = 2'b00,
    OP_AND  = 2'b01,
    OP_NOT  = 2'b10,
    OP_OR   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SETTLE = 2'b01,
    ST_DONE   = 2'b10
  } state_e;

endpackage

// File: rtl/bitwise_opnd_prep.sv
// Operand preconditioning so one NAND array realises NAND, AND, NOT and OR;
// res_inv tells the capture stage to invert the NAND output.
module bitwise_opnd_prep
  import bitwise_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] unit_a_next,
  output logic [WIDTH-1:0] unit_b_next,
  output logic             res_inv
);

  always_comb begin
    unit_a_next = a;
    unit_b_next = b;
    res_inv     = 1'b0;
    case (op)
      OP_AND: res_inv = 1'b1;
      OP_NOT: unit_b_next = '1;
      // De Morgan: a | b == ~(~a & ~b)
      OP_OR: begin
        unit_a_next = ~a;
        unit_b_next = ~b;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/bitwise_op_sequencer.sv
// Valid/ready sequencer around a 32-bit NAND unit: preconditions operands,
// holds them for SETTLE_CYCLES, then captures result and flags.
// Optional op_count output enabled by macro BITWISE_SEQ_STATS_EN.
module bitwise_op_sequencer
  import bitwise_pkg::*;
#(
  parameter int WIDTH         = WIDTH_DEF,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] unit_a,
  output logic [WIDTH-1:0] unit_b,
  input  logic [WIDTH-1:0] unit_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_allones
`ifdef BITWISE_SEQ_STATS_EN
  ,
  output logic [15:0]      op_count
`endif
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] ua_q, ua_d, ub_q, ub_d, res_q, res_d;
  logic             inv_q, inv_d, vld_q, vld_d, zero_q, zero_d, ones_q, ones_d;
  logic [WIDTH-1:0] prep_a, prep_b;
  logic             prep_inv, accept;

  bitwise_opnd_prep #(.WIDTH(WIDTH)) u_prep (
    .op          (in_op),
    .a           (in_a),
    .b           (in_b),
    .unit_a_next (prep_a),
    .unit_b_next (prep_b),
    .res_inv     (prep_inv)
  );

  assign in_ready = rst_n &&
                    ((state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready));
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ua_d    = ua_q;
    ub_d    = ub_q;
    inv_d   = inv_q;
    res_d   = res_q;
    zero_d  = zero_q;
    ones_d  = ones_q;
    vld_d   = vld_q;
    case (state_q)
      ST_SETTLE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          res_d   = inv_q ? ~unit_y : unit_y;
          zero_d  = ~|res_d;
          ones_d  = &res_d;
          vld_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          vld_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: ;
    endcase
    // Accept is only possible from IDLE or a consumed DONE, so it overrides both.
    if (accept) begin
      ua_d    = prep_a;
      ub_d    = prep_b;
      inv_d   = prep_inv;
      cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
      state_d = ST_SETTLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ua_q    <= '0;
      ub_q    <= '0;
      inv_q   <= 1'b0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      ones_q  <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ua_q    <= ua_d;
      ub_q    <= ub_d;
      inv_q   <= inv_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      ones_q  <= ones_d;
      vld_q   <= vld_d;
    end
  end

  assign unit_a      = ua_q;
  assign unit_b      = ub_q;
  assign out_valid   = vld_q;
  assign out_result  = res_q;
  assign out_zero    = zero_q;
  assign out_allones = ones_q;

`ifdef BITWISE_SEQ_STATS_EN
  logic [15:0] op_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count_q <= '0;
    end else if (vld_q && out_ready) begin
      op_count_q <= op_count_q + 16'd1;
    end
  end

  assign op_count = op_count_q;
`endif

endmodule

// File: tb/tb_bitwise_op_sequencer.sv
// Self-checking bench for bitwise_op_sequencer with a behavioural NAND unit
// and an operation-level reference model.
module tb_bitwise_op_sequencer;
  localparam int W = 32;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0, in_ready;
  logic [1:0]   in_op = 2'b00;
  logic [W-1:0] in_a = '0, in_b = '0;
  logic [W-1:0] unit_a, unit_b, unit_y;
  logic         out_valid, out_ready = 1'b0;
  logic [W-1:0] out_result;
  logic         out_zero, out_allones;
`ifdef BITWISE_SEQ_STATS_EN
  logic [15:0]  op_count;
  int           exp_cnt = 0;
`endif

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign unit_y = ~(unit_a & unit_b);

  bitwise_op_sequencer #(.WIDTH(W), .SETTLE_CYCLES(S)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_a        (in_a),
    .in_b        (in_b),
    .unit_a      (unit_a),
    .unit_b      (unit_b),
    .unit_y      (unit_y),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_zero    (out_zero),
    .out_allones (out_allones)
`ifdef BITWISE_SEQ_STATS_EN
    ,
    .op_count    (op_count)
`endif
  );

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_res;
    logic         exp_zero;
    logic         exp_ones;
    logic [W-1:0] exp_ub;
  } vec_t;

  vec_t vecs[6];

  function automatic logic [W-1:0] ref_op(input logic [1:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    case (op)
      2'b00:   return ~(a & b);
      2'b01:   return a & b;
      2'b10:   return ~a;
      default: return a | b;
    endcase
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Presents a request, waits for accept and then for out_valid; lat = edges after accept.
  task automatic start_and_wait(input logic [1:0] op, input logic [W-1:0] a,
                                input logic [W-1:0] b, output int lat);
    int n;
    in_op = op; in_a = a; in_b = b; in_valid = 1'b1; out_ready = 1'b0;
    n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    chk("accept_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    chk("result_timeout", {31'd0, out_valid}, 32'd1);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
`ifdef BITWISE_SEQ_STATS_EN
    exp_cnt++;
`endif
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int hold);
    int lat;
    logic [W-1:0] e;
    e = ref_op(op, a, b);
    start_and_wait(op, a, b, lat);
    chk({tag, "_latency"}, W'(lat), W'(S));
    for (int i = 0; i < hold; i++) begin @(posedge clk); #1; end
    chk({tag, "_result"}, out_result, e);
    chk({tag, "_zero"}, {31'd0, out_zero}, {31'd0, (e == '0)});
    chk({tag, "_allones"}, {31'd0, out_allones}, {31'd0, (e == '1)});
    consume();
  endtask

  initial begin
    int lat;
    logic [W-1:0] r0;
    logic seen;

    vecs[0] = '{2'b00, 32'hFFFF0000, 32'hFF00FF00, 32'h00FFFFFF, 1'b0, 1'b0, 32'hFF00FF00};
    vecs[1] = '{2'b01, 32'hAAAAAAAA, 32'h55555555, 32'h00000000, 1'b1, 1'b0, 32'h55555555};
    vecs[2] = '{2'b11, 32'hAAAAAAAA, 32'h55555555, 32'hFFFFFFFF, 1'b0, 1'b1, 32'hAAAAAAAA};
    vecs[3] = '{2'b10, 32'h0000FFFF, 32'h12345678, 32'hFFFF0000, 1'b0, 1'b0, 32'hFFFFFFFF};
    vecs[4] = '{2'b00, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h00000000};
    vecs[5] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 32'hFFFFFFFF};

    #2;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_unit_a", unit_a, 32'd0);
    chk("rst_unit_b", unit_b, 32'd0);
    chk("rst_result", out_result, 32'd0);
    chk("rst_flags", {30'd0, out_zero, out_allones}, 32'd0);
    #20 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_in_ready", {31'd0, in_ready}, 32'd1);

    for (int i = 0; i < 6; i++) begin
      start_and_wait(vecs[i].op, vecs[i].a, vecs[i].b, lat);
      chk($sformatf("vec%0d_latency", i), W'(lat), W'(S));
      chk($sformatf("vec%0d_result", i), out_result, vecs[i].exp_res);
      chk($sformatf("vec%0d_zero", i), {31'd0, out_zero}, {31'd0, vecs[i].exp_zero});
      chk($sformatf("vec%0d_allones", i), {31'd0, out_allones}, {31'd0, vecs[i].exp_ones});
      chk($sformatf("vec%0d_unit_b", i), unit_b, vecs[i].exp_ub);
      consume();
      chk($sformatf("vec%0d_drop", i), {31'd0, out_valid}, 32'd0);
      chk($sformatf("vec%0d_retain", i), out_result, vecs[i].exp_res);
    end

    // Backpressure with a pending request, then back-to-back accept.
    start_and_wait(2'b00, 32'h12345678, 32'h0F0F0F0F, lat);
    r0 = out_result;
    chk("bp_first", r0, ref_op(2'b00, 32'h12345678, 32'h0F0F0F0F));
    in_op = 2'b01; in_a = 32'hAAAAAAAA; in_b = 32'h55555555; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_hold%0d", i), out_result, r0);
      chk($sformatf("bp_valid%0d", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("bp_in_ready%0d", i), {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    #1 chk("b2b_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
`ifdef BITWISE_SEQ_STATS_EN
    exp_cnt++;
`endif
    chk("b2b_valid_drop", {31'd0, out_valid}, 32'd0);
    lat = 0;
    while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    chk("b2b_latency", W'(lat), W'(S));
    chk("b2b_result", out_result, 32'h00000000);
    chk("b2b_zero", {31'd0, out_zero}, 32'd1);
    consume();

    // Reset during SETTLE discards the operation.
    run_op("pre_rst", 2'b00, 32'hFFFF0000, 32'hFF00FF00, 0);
    in_op = 2'b11; in_a = 32'hC0FFEE00; in_b = 32'h0000BEEF; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_result", out_result, 32'd0);
    chk("mid_rst_unit_a", unit_a, 32'd0);
    chk("mid_rst_unit_b", unit_b, 32'd0);
    @(posedge clk); #3 rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("post_rst_no_pulse", {31'd0, seen}, 32'd0);
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef BITWISE_SEQ_STATS_EN
    exp_cnt = 0;
`endif

    // Randomised operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic [1:0] op;
      logic [W-1:0] a, b;
      op = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 5) == 0) a = '1;
      if ($urandom_range(0, 5) == 0) b = ~a;
      run_op($sformatf("rnd%0d", i), op, a, b, $urandom_range(0, 3));
    end

`ifdef BITWISE_SEQ_STATS_EN
    chk("op_count", {16'd0, op_count}, W'(exp_cnt));
    force dut.op_count_q = 16'hFFFF;
    @(posedge clk); #1;
    release dut.op_count_q;
    run_op("wrap", 2'b00, 32'h1, 32'h1, 0);
    chk("op_count_wrap", {16'd0, op_count}, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end
endmodule
